// File: rtl/l2_wb_drain_if.sv
// LLC write-back channel between the L2 write-buffer drain engine (master)
// and the LLC (slave): request handshake with payload plus the ack strobe.
`timescale 1ns/1ps
interface l2_wb_drain_if #(
  parameter int WB_BITS        = 2,
  parameter int ADDR_BITS      = 28,
  parameter int LINE_BITS      = 128,
  parameter int WORD_MASK_BITS = 4,
  parameter int HPROT_BITS     = 1
);
  logic                      llc_req_valid;
  logic                      llc_req_ready;
  logic [ADDR_BITS-1:0]      llc_req_addr;
  logic [LINE_BITS-1:0]      llc_req_line;
  logic [WORD_MASK_BITS-1:0] llc_req_word_mask;
  logic [HPROT_BITS-1:0]     llc_req_hprot;
  logic [WB_BITS-1:0]        llc_req_id;
  logic                      llc_rsp_valid;

  modport master (
    output llc_req_valid, llc_req_addr, llc_req_line, llc_req_word_mask,
           llc_req_hprot, llc_req_id,
    input  llc_req_ready, llc_rsp_valid
  );

  modport slave (
    input  llc_req_valid, llc_req_addr, llc_req_line, llc_req_word_mask,
           llc_req_hprot, llc_req_id,
    output llc_req_ready, llc_rsp_valid
  );
endinterface

// File: rtl/l2_wb_drain.sv
// L2 write-buffer drain engine: flushes all valid WB entries (drain) or one entry (evict) to the LLC.
// Define L2_WB_DRAIN_RR_EN for round-robin entry selection; otherwise the lowest valid index wins.
`timescale 1ns/1ps
module l2_wb_drain #(
  parameter int N_WB            = 4,
  parameter int WB_BITS         = 2,
  parameter int ADDR_BITS       = 28,
  parameter int LINE_BITS       = 128,
  parameter int WORD_MASK_BITS  = 4,
  parameter int HPROT_BITS      = 1,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      drain_start,
  input  logic                      evict_req,
  input  logic [N_WB-1:0]           wb_valid_mask,
  output logic [WB_BITS-1:0]        rd_idx,
  input  logic [ADDR_BITS-1:0]      rd_addr,
  input  logic [LINE_BITS-1:0]      rd_line,
  input  logic [WORD_MASK_BITS-1:0] rd_word_mask,
  input  logic [HPROT_BITS-1:0]     rd_hprot,
  l2_wb_drain_if.master             llc,
  output logic                      clear_valid,
  output logic [WB_BITS-1:0]        clear_idx,
  output logic                      busy,
  output logic                      drain_done,
  output logic                      rsp_err
);

  localparam int OUT_BITS = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [OUT_BITS-1:0] MAX_OUT = OUT_BITS'(MAX_OUTSTANDING);

  typedef enum logic [1:0] {IDLE, SELECT, ISSUE, WAIT_ACK} state_e;
  typedef enum logic {DRAIN, SINGLE} mode_e;

  state_e                    state_q, state_d;
  mode_e                     mode_q, mode_d;
  logic [OUT_BITS-1:0]       outstanding_q, outstanding_d;
  logic                      rsp_err_q, rsp_err_d;
  logic [ADDR_BITS-1:0]      req_addr_q, req_addr_d;
  logic [LINE_BITS-1:0]      req_line_q, req_line_d;
  logic [WORD_MASK_BITS-1:0] req_word_mask_q, req_word_mask_d;
  logic [HPROT_BITS-1:0]     req_hprot_q, req_hprot_d;
  logic [WB_BITS-1:0]        req_id_q, req_id_d;
`ifdef L2_WB_DRAIN_RR_EN
  logic [WB_BITS-1:0]        rr_ptr_q, rr_ptr_d;
`endif

  logic               cand_found;
  logic [WB_BITS-1:0] cand_idx;
  logic               req_valid;
  logic               hs;

  // Scan from the far end so the last hit is the first entry in search order.
  always_comb begin
    cand_found = 1'b0;
    cand_idx   = '0;
    for (int i = N_WB - 1; i >= 0; i--) begin
`ifdef L2_WB_DRAIN_RR_EN
      if (wb_valid_mask[(int'(rr_ptr_q) + i) % N_WB]) begin
        cand_found = 1'b1;
        cand_idx   = WB_BITS'((int'(rr_ptr_q) + i) % N_WB);
      end
`else
      if (wb_valid_mask[i]) begin
        cand_found = 1'b1;
        cand_idx   = WB_BITS'(i);
      end
`endif
    end
  end

  assign req_valid = (state_q == ISSUE) && (outstanding_q < MAX_OUT);
  assign hs        = req_valid && llc.llc_req_ready;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latch).
    state_d         = state_q;
    mode_d          = mode_q;
    outstanding_d   = outstanding_q;
    rsp_err_d       = rsp_err_q;
    req_addr_d      = req_addr_q;
    req_line_d      = req_line_q;
    req_word_mask_d = req_word_mask_q;
    req_hprot_d     = req_hprot_q;
    req_id_d        = req_id_q;
`ifdef L2_WB_DRAIN_RR_EN
    rr_ptr_d        = rr_ptr_q;
`endif
    clear_valid     = 1'b0;
    drain_done      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (drain_start) begin
          state_d = SELECT;
          mode_d  = DRAIN;
        end else if (evict_req) begin
          state_d = SELECT;
          mode_d  = SINGLE;
        end
      end
      SELECT: begin
        if (cand_found) begin
          req_addr_d      = rd_addr;
          req_line_d      = rd_line;
          req_word_mask_d = rd_word_mask;
          req_hprot_d     = rd_hprot;
          req_id_d        = cand_idx;
          state_d         = ISSUE;
        end else begin
          state_d = (mode_q == DRAIN) ? WAIT_ACK : IDLE;
        end
      end
      ISSUE: begin
        if (hs) begin
          clear_valid = 1'b1;
`ifdef L2_WB_DRAIN_RR_EN
          rr_ptr_d    = WB_BITS'((int'(req_id_q) + 1) % N_WB);
`endif
          state_d     = (mode_q == DRAIN) ? SELECT : IDLE;
        end
      end
      WAIT_ACK: begin
        if (outstanding_q == '0) begin
          drain_done = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Acks are counted in every state, including after a single evict returned to IDLE.
    unique case ({hs, llc.llc_rsp_valid})
      2'b10: outstanding_d = outstanding_q + 1'b1;
      2'b01: begin
        if (outstanding_q != '0) outstanding_d = outstanding_q - 1'b1;
        else                     rsp_err_d     = 1'b1;
      end
      default: outstanding_d = outstanding_q;
    endcase
  end

  // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      mode_q          <= SINGLE;
      outstanding_q   <= '0;
      rsp_err_q       <= 1'b0;
      // NOTE: the payload is reset too so llc_req_* never exposes pre-reset contents.
      req_addr_q      <= '0;
      req_line_q      <= '0;
      req_word_mask_q <= '0;
      req_hprot_q     <= '0;
      req_id_q        <= '0;
`ifdef L2_WB_DRAIN_RR_EN
      rr_ptr_q        <= '0;
`endif
    end else begin
      state_q         <= state_d;
      mode_q          <= mode_d;
      outstanding_q   <= outstanding_d;
      rsp_err_q       <= rsp_err_d;
      req_addr_q      <= req_addr_d;
      req_line_q      <= req_line_d;
      req_word_mask_q <= req_word_mask_d;
      req_hprot_q     <= req_hprot_d;
      req_id_q        <= req_id_d;
`ifdef L2_WB_DRAIN_RR_EN
      rr_ptr_q        <= rr_ptr_d;
`endif
    end
  end

  assign rd_idx                = cand_idx;
  assign llc.llc_req_valid     = req_valid;
  assign llc.llc_req_addr      = req_addr_q;
  assign llc.llc_req_line      = req_line_q;
  assign llc.llc_req_word_mask = req_word_mask_q;
  assign llc.llc_req_hprot     = req_hprot_q;
  assign llc.llc_req_id        = req_id_q;
  assign clear_idx             = req_id_q;
  assign busy                  = (state_q != IDLE);
  assign rsp_err               = rsp_err_q;

endmodule

// File: tb/tb_l2_wb_drain.sv
// Self-checking bench for l2_wb_drain: behavioural WB array, auto-acking LLC, and a request scoreboard.
`timescale 1ns/1ps
module tb_l2_wb_drain;
  localparam int N_WB = 4;
  localparam int WB_BITS = 2;
  localparam int ADDR_BITS = 28;
  localparam int LINE_BITS = 128;
  localparam int WORD_MASK_BITS = 4;
  localparam int HPROT_BITS = 1;
  localparam int MAX_OUTSTANDING = 2;

  typedef struct {
    logic [WB_BITS-1:0]        id;
    logic [ADDR_BITS-1:0]      addr;
    logic [LINE_BITS-1:0]      line;
    logic [WORD_MASK_BITS-1:0] wm;
    logic [HPROT_BITS-1:0]     hp;
  } req_t;

  logic                      clk = 1'b0;
  logic                      rst;
  logic                      drain_start, evict_req;
  logic [N_WB-1:0]           wb_mask;
  logic [WB_BITS-1:0]        rd_idx;
  logic [ADDR_BITS-1:0]      rd_addr;
  logic [LINE_BITS-1:0]      rd_line;
  logic [WORD_MASK_BITS-1:0] rd_word_mask;
  logic [HPROT_BITS-1:0]     rd_hprot;
  logic                      clear_valid;
  logic [WB_BITS-1:0]        clear_idx;
  logic                      busy, drain_done, rsp_err;
  logic                      ready_r, auto_rsp, manual_rsp;

  logic [ADDR_BITS-1:0]      wb_addr  [N_WB];
  logic [LINE_BITS-1:0]      wb_line  [N_WB];
  logic [WORD_MASK_BITS-1:0] wb_wmask [N_WB];
  logic [HPROT_BITS-1:0]     wb_hprot [N_WB];

  req_t exp_q[$];
  int   ack_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   model_out = 0;
  int   ack_delay = 3;
  int   last_ack_cyc = -1;
  logic               clr_pend;
  logic [WB_BITS-1:0] clr_idx_pend;

  l2_wb_drain_if llc_if ();
  assign llc_if.llc_req_ready = ready_r;
  assign llc_if.llc_rsp_valid = auto_rsp | manual_rsp;

  assign rd_addr      = wb_addr[rd_idx];
  assign rd_line      = wb_line[rd_idx];
  assign rd_word_mask = wb_wmask[rd_idx];
  assign rd_hprot     = wb_hprot[rd_idx];

  l2_wb_drain #(
    .N_WB(N_WB), .WB_BITS(WB_BITS), .ADDR_BITS(ADDR_BITS), .LINE_BITS(LINE_BITS),
    .WORD_MASK_BITS(WORD_MASK_BITS), .HPROT_BITS(HPROT_BITS), .MAX_OUTSTANDING(MAX_OUTSTANDING)
  ) dut (
    .clk(clk), .rst(rst), .drain_start(drain_start), .evict_req(evict_req),
    .wb_valid_mask(wb_mask), .rd_idx(rd_idx), .rd_addr(rd_addr), .rd_line(rd_line),
    .rd_word_mask(rd_word_mask), .rd_hprot(rd_hprot), .llc(llc_if),
    .clear_valid(clear_valid), .clear_idx(clear_idx), .busy(busy),
    .drain_done(drain_done), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // WB invalidation and LLC ack generation, applied just after each rising edge.
  always @(posedge clk) begin
    #1;
    if (clr_pend) begin
      wb_mask[clr_idx_pend] = 1'b0;
      clr_pend = 1'b0;
    end
    auto_rsp = (ack_q.size() > 0) && (ack_q[0] <= cyc);
    if (auto_rsp) begin
      void'(ack_q.pop_front());
      last_ack_cyc = cyc;
    end
  end

  // Scoreboard monitor: sampled on the falling edge, mid-cycle.
  always @(negedge clk) begin
    logic hs;
    logic rsp;
    req_t e;
    if (!rst) begin
      hs  = llc_if.llc_req_valid && ready_r;
      rsp = llc_if.llc_rsp_valid;
      checks++;
      if (clear_valid !== hs) begin
        errors++;
        $display("FAIL clear_valid_vs_handshake cyc=%0d got=%b exp=%b", cyc, clear_valid, hs);
      end
      if (llc_if.llc_req_valid) begin
        checks++;
        if (model_out >= MAX_OUTSTANDING) begin
          errors++;
          $display("FAIL throttle cyc=%0d req_valid with outstanding=%0d", cyc, model_out);
        end
      end
      if (hs) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_req cyc=%0d id=%0d exp=none", cyc, llc_if.llc_req_id);
        end else begin
          e = exp_q.pop_front();
          if ({llc_if.llc_req_id, llc_if.llc_req_addr, llc_if.llc_req_line,
               llc_if.llc_req_word_mask, llc_if.llc_req_hprot, clear_idx} !==
              {e.id, e.addr, e.line, e.wm, e.hp, e.id}) begin
            errors++;
            $display("FAIL req_payload cyc=%0d got id=%0d clr=%0d addr=%h line=%h wm=%h hp=%h exp id=%0d addr=%h line=%h wm=%h hp=%h",
                     cyc, llc_if.llc_req_id, clear_idx, llc_if.llc_req_addr, llc_if.llc_req_line,
                     llc_if.llc_req_word_mask, llc_if.llc_req_hprot, e.id, e.addr, e.line, e.wm, e.hp);
          end
        end
        clr_pend     = 1'b1;
        clr_idx_pend = llc_if.llc_req_id;
        ack_q.push_back(cyc + ack_delay);
      end
      if (hs && !rsp) model_out++;
      else if (!hs && rsp && model_out > 0) model_out--;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic look();
    @(negedge clk);
  endtask

  task automatic push_exp(input int i);
    req_t e;
    e.id   = WB_BITS'(i);
    e.addr = wb_addr[i];
    e.line = wb_line[i];
    e.wm   = wb_wmask[i];
    e.hp   = wb_hprot[i];
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    tick();
    rst = 1'b1; ready_r = 1'b0; drain_start = 1'b0; evict_req = 1'b0; manual_rsp = 1'b0;
    exp_q.delete(); ack_q.delete(); clr_pend = 1'b0;
    tick();
    exp_q.delete(); ack_q.delete(); clr_pend = 1'b0;
    tick();
    rst = 1'b0; model_out = 0;
  endtask

  task automatic test_reset();
    do_reset();
    look();
    checks++;
    if ({llc_if.llc_req_valid, llc_if.llc_req_addr, llc_if.llc_req_line, llc_if.llc_req_word_mask,
         llc_if.llc_req_hprot, llc_if.llc_req_id} !== '0) begin
      errors++;
      $display("FAIL reset_req got valid=%b addr=%h id=%0d exp all zero",
               llc_if.llc_req_valid, llc_if.llc_req_addr, llc_if.llc_req_id);
    end
    checks++;
    if ({clear_valid, drain_done, rsp_err, busy} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_status got clr/done/err/busy=%b exp=0000",
               {clear_valid, drain_done, rsp_err, busy});
    end
  endtask

  task automatic test_single_evict();
    do_reset();
    ack_delay = 3; wb_mask = 4'b1010; ready_r = 1'b1;
    push_exp(1);
    evict_req = 1'b1;
    tick(); evict_req = 1'b0;
    look();
    checks++;
    if ({busy, rd_idx, llc_if.llc_req_valid} !== {1'b1, 2'd1, 1'b0}) begin
      errors++;
      $display("FAIL evict_select got busy=%b rd_idx=%0d valid=%b exp 1/1/0", busy, rd_idx, llc_if.llc_req_valid);
    end
    tick(); look();
    checks++;
    if ({llc_if.llc_req_valid, llc_if.llc_req_id, clear_valid, clear_idx} !== {1'b1, 2'd1, 1'b1, 2'd1}) begin
      errors++;
      $display("FAIL evict_issue got valid=%b id=%0d clr=%b clr_idx=%0d exp 1/1/1/1",
               llc_if.llc_req_valid, llc_if.llc_req_id, clear_valid, clear_idx);
    end
    tick(); look();
    checks++;
    if ({busy, llc_if.llc_req_valid} !== 2'b00) begin
      errors++;
      $display("FAIL evict_idle got busy=%b valid=%b exp 0/0", busy, llc_if.llc_req_valid);
    end
    repeat (4) tick();
  endtask

  task automatic run_drain(input int delay, input logic with_evict, input string name);
    int done_cyc;
    do_reset();
    ack_delay = delay; wb_mask = 4'b1111; ready_r = 1'b1;
    for (int i = 0; i < N_WB; i++) push_exp(i);
    drain_start = 1'b1; evict_req = with_evict;
    tick(); drain_start = 1'b0; evict_req = 1'b0;
    done_cyc = -1;
    for (int i = 0; i < 200; i++) begin
      look();
      if (drain_done) begin
        done_cyc = cyc;
        break;
      end
      tick();
    end
    checks++;
    if (done_cyc < 0) begin
      errors++;
      $display("FAIL %s_timeout no drain_done within 200 cycles", name);
    end else begin
      checks++;
      if (exp_q.size() != 0 || wb_mask !== 4'b0000 || ack_q.size() != 0) begin
        errors++;
        $display("FAIL %s_complete got pending_req=%0d wb_mask=%b pending_ack=%0d exp 0/0000/0",
                 name, exp_q.size(), wb_mask, ack_q.size());
      end
      checks++;
      if (done_cyc <= last_ack_cyc) begin
        errors++;
        $display("FAIL %s_done_order got done_cyc=%0d last_ack=%0d exp done after ack", name, done_cyc, last_ack_cyc);
      end
      tick(); look();
      checks++;
      if ({drain_done, busy} !== 2'b00) begin
        errors++;
        $display("FAIL %s_done_pulse got done=%b busy=%b exp 0/0", name, drain_done, busy);
      end
    end
  endtask

  task automatic test_drain();
    run_drain(3, 1'b1, "drain");
  endtask

  task automatic test_throttle();
    run_drain(10, 1'b0, "throttle");
  endtask

  task automatic test_empty_drain();
    do_reset();
    wb_mask = 4'b0000; ready_r = 1'b1;
    drain_start = 1'b1;
    tick(); drain_start = 1'b0;
    look();
    checks++;
    if ({busy, drain_done} !== 2'b10) begin
      errors++;
      $display("FAIL empty_c1 got busy=%b done=%b exp 1/0", busy, drain_done);
    end
    tick(); look();
    checks++;
    if ({drain_done, llc_if.llc_req_valid} !== 2'b10) begin
      errors++;
      $display("FAIL empty_c2 got done=%b valid=%b exp 1/0", drain_done, llc_if.llc_req_valid);
    end
    tick(); look();
    checks++;
    if ({busy, drain_done} !== 2'b00) begin
      errors++;
      $display("FAIL empty_c3 got busy=%b done=%b exp 0/0", busy, drain_done);
    end
  endtask

  task automatic test_stall();
    req_t e;
    logic [ADDR_BITS-1:0] orig_addr;
    logic [LINE_BITS-1:0] orig_line;
    do_reset();
    ack_delay = 3; wb_mask = 4'b0100; ready_r = 1'b0;
    push_exp(2);
    e = exp_q[0];
    evict_req = 1'b1;
    tick(); evict_req = 1'b0;
    tick();
    orig_addr = wb_addr[2]; orig_line = wb_line[2];
    wb_addr[2] = ~orig_addr; wb_line[2] = ~orig_line;
    for (int k = 0; k < 5; k++) begin
      look();
      checks++;
      if ({llc_if.llc_req_valid, clear_valid, llc_if.llc_req_id, llc_if.llc_req_addr, llc_if.llc_req_line} !==
          {1'b1, 1'b0, e.id, e.addr, e.line}) begin
        errors++;
        $display("FAIL stall_hold k=%0d got valid=%b clr=%b id=%0d addr=%h exp 1/0/%0d/%h",
                 k, llc_if.llc_req_valid, clear_valid, llc_if.llc_req_id, llc_if.llc_req_addr, e.id, e.addr);
      end
      tick();
      drain_start = (k == 0);
    end
    drain_start = 1'b0; ready_r = 1'b1;
    look();
    checks++;
    if (clear_valid !== 1'b1) begin
      errors++;
      $display("FAIL stall_release got clr=%b exp 1", clear_valid);
    end
    tick(); ready_r = 1'b0;
    look();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL stall_ignore_drain got busy=%b exp 0", busy);
    end
    wb_addr[2] = orig_addr; wb_line[2] = orig_line;
    repeat (4) tick();
  endtask

  task automatic test_rsp_err_rst();
    do_reset();
    manual_rsp = 1'b1;
    tick(); manual_rsp = 1'b0;
    look();
    checks++;
    if (rsp_err !== 1'b1) begin
      errors++;
      $display("FAIL rsp_err_set got %b exp 1", rsp_err);
    end
    repeat (3) tick();
    look();
    checks++;
    if ({rsp_err, busy} !== 2'b10) begin
      errors++;
      $display("FAIL rsp_err_sticky got err=%b busy=%b exp 1/0", rsp_err, busy);
    end
    wb_mask = 4'b0001; ready_r = 1'b0;
    evict_req = 1'b1;
    tick(); evict_req = 1'b0;
    tick(); look();
    checks++;
    if (llc_if.llc_req_valid !== 1'b1) begin
      errors++;
      $display("FAIL rst_pre_issue got valid=%b exp 1", llc_if.llc_req_valid);
    end
    tick(); rst = 1'b1;
    tick(); look();
    checks++;
    if ({llc_if.llc_req_valid, busy, rsp_err, clear_valid, wb_mask[0]} !== 5'b00001) begin
      errors++;
      $display("FAIL rst_mid_issue got valid/busy/err/clr/wb0=%b exp 00001",
               {llc_if.llc_req_valid, busy, rsp_err, clear_valid, wb_mask[0]});
    end
    do_reset();
  endtask

  task automatic test_rr();
    do_reset();
    ack_delay = 3; ready_r = 1'b1; wb_mask = 4'b1111;
    push_exp(0);
`ifdef L2_WB_DRAIN_RR_EN
    push_exp(1);
`else
    push_exp(0);
`endif
    for (int pass = 0; pass < 2; pass++) begin
      evict_req = 1'b1;
      tick(); evict_req = 1'b0;
      for (int i = 0; i < 20; i++) begin
        look();
        if (!busy) break;
        tick();
      end
      checks++;
      if (busy !== 1'b0) begin
        errors++;
        $display("FAIL rr_idle_timeout pass=%0d busy=%b exp 0", pass, busy);
      end
      tick();
      wb_mask = 4'b1111;
    end
    repeat (5) tick();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL rr_order got pending=%0d exp 0", exp_q.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; drain_start = 1'b0; evict_req = 1'b0; ready_r = 1'b0;
    manual_rsp = 1'b0; auto_rsp = 1'b0; clr_pend = 1'b0; clr_idx_pend = '0; wb_mask = '0;
    for (int i = 0; i < N_WB; i++) begin
      wb_addr[i]  = ADDR_BITS'($urandom);
      wb_line[i]  = {$urandom, $urandom, $urandom, $urandom};
      wb_wmask[i] = WORD_MASK_BITS'($urandom);
      wb_hprot[i] = HPROT_BITS'($urandom);
    end
    test_reset();
    test_single_evict();
    test_drain();
    test_throttle();
    test_empty_drain();
    test_stall();
    test_rsp_err_rst();
    test_rr();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
